uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver; the receive-side counterpart of the UART transmitter in the same block. Recovers 8N1-style frames (one start bit, DATA_BITS data bits LSB first, one stop bit, no parity) from an asynchronous serial line. Uses a fixed clocks-per-bit count and mid-bit sampling. Delivers each byte to the bus-facing logic as a one-cycle valid pulse, and flags framing errors.

## Interface
- DATA_BITS, 8, data bits per frame
- CYCLES_PER_BIT, 108, i_clk cycles per bit; must be ≥ 8; HALF = CYCLES_PER_BIT/2 (integer floor)
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_rx  in  1  serial line; idle high; asynchronous to i_clk
- o_data  out  DATA_BITS  last good received word; reset 0; changes only with o_valid
- o_valid  out  1  one-cycle pulse, o_data newly valid; reset 0
- o_frame_err  out  1  one-cycle pulse, stop bit sampled low; reset 0
- o_busy  out  1  high in any state other than IDLE; reset 0

## Operation
- i_rx passes through a 2-flop synchronizer; both flops reset to 1. rx_s denotes the synchronized output.
- Bit counter cnt is $clog2(CYCLES_PER_BIT) wide and counts down. The sample point is cnt==0.
- Bit index idx is $clog2(DATA_BITS+1) wide. The shift register sr is DATA_BITS wide.
- State machine:
  - IDLE:
    - rx_s==0 → START, cnt=HALF-1.
  - START, at sample:
    - rx_s==0 → DATA, cnt=CYCLES_PER_BIT-1, idx=0.
    - rx_s==1 → IDLE (false start). No output pulse.
  - DATA, at sample:
    - Shift the bit into the MSB of sr (right shift), so LSB-first arrival ends with bit 0 at sr[0].
    - idx increments and cnt reloads.
    - After the DATA_BITS-th bit → STOP.
  - STOP, at sample:
    - rx_s==1 → o_data=sr, o_valid=1, then IDLE.
    - rx_s==0 → o_frame_err=1, o_data held, then BREAK.
  - BREAK:
    - Wait for rx_s==1, then IDLE. Covers a line held low, or a break condition.
- Return to IDLE happens at the mid-stop-bit sample, not at stop-bit end. A start edge arriving half a bit later is therefore caught.
- Any other state encoding forces IDLE on the next cycle.
- i_rst asserted mid-frame: immediate return to IDLE, all outputs 0, sr=0, partial frame discarded. No pulse on deassertion.

## Timing
- Edge k is the first rising i_clk edge at which i_rx is sampled low. Each step below is the earlier step + the stated edges:
  - First synchronizer flop captures 0 at edge k.
  - rx_s reads 0 from edge k+1.
  - FSM enters START at edge k+2.
  - Start-bit sample at edge k+2+HALF.
  - Data bit n sample at edge k+2+HALF+(n+1)·CYCLES_PER_BIT.
  - Stop sample at edge k+2+HALF+(DATA_BITS+1)·CYCLES_PER_BIT; o_valid or o_frame_err is registered high after this edge.
- o_valid and o_frame_err are high for exactly one cycle and are never both high.
- o_busy rises at edge k+2 and falls with the stop-sample edge (or on BREAK exit).
- No backpressure: a consumer that misses the o_valid cycle loses that word.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each sample decision (start, data, stop) is the 2-of-3 majority of rx_s taken at cnt==2, 1 and 0.
  - The decision is made at cnt==0; cycle timing is unchanged.
  - Suppresses single-cycle line glitches.
- UART_RX_MAJORITY_EN undefined: each decision is the single value of rx_s at cnt==0.

## Test plan
- Frame 0xA5, CYCLES_PER_BIT=108: start edge at k → o_data=0xA5 and a single o_valid pulse after edge k+2+54+9·108 = k+1028; o_frame_err stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap → two o_valid pulses, 1080 cycles apart, o_data 0x00 then 0xFF.
- i_rx low for 20 cycles then high (shorter than HALF) → START aborts to IDLE; no o_valid, no o_frame_err; o_busy low again at the start-sample edge.
- Frame 0x3C with stop bit driven low for 2 bit times → o_frame_err pulses once and o_data holds its previous value. FSM stays in BREAK (o_busy=1) until the line returns high. The next valid frame 0x81 is received correctly.
- i_rst pulsed mid-data-bit 4 of frame 0x5A → all outputs 0 immediately. The remainder of the frame produces no pulse unless its tail looks like a valid frame. A subsequent clean 0x5A is received.
- UART_RX_MAJORITY_EN defined: a 1-cycle high glitch exactly at the mid-point of data bit 3 of 0x00 → o_data=0x00. With the macro undefined, the same stimulus → o_data=0x08.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with mid-bit sampling, valid/frame-error pulses.
// Define UART_RX_MAJORITY_EN to take each bit decision as a 2-of-3 vote around mid-bit.
module uart_rx #(
  parameter int DATA_BITS      = 8,
  parameter int CYCLES_PER_BIT = 108
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);
  localparam int HALF = CYCLES_PER_BIT / 2;
  localparam int CW   = $clog2(CYCLES_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t                state_q, state_d;
  logic                  s1_q, s2_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]  sr_q, sr_d, data_q, data_d;
  logic                  valid_q, valid_d, ferr_q, ferr_d;
  logic                  rx_s, tick, bit_s;
  assign rx_s = s2_q;
  assign tick = cnt_q == '0;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] h_q;
  // h_q[0] holds rx_s at cnt==1 and h_q[1] at cnt==2 when tick is seen
  assign bit_s = (h_q[1] & h_q[0]) | (h_q[1] & rx_s) | (h_q[0] & rx_s);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) h_q <= 2'b11;
    else       h_q <= {h_q[0], rx_s};
`else
  assign bit_s = rx_s;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= i_rx;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    idx_d   = idx_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = CW'(HALF - 1);
      end
      START: if (tick) begin
        state_d = bit_s ? IDLE : DATA;
        cnt_d   = CW'(CYCLES_PER_BIT - 1);
        idx_d   = '0;
      end
      DATA: if (tick) begin
        sr_d    = {bit_s, sr_q[DATA_BITS-1:1]};
        idx_d   = idx_q + 1'b1;
        cnt_d   = CW'(CYCLES_PER_BIT - 1);
        state_d = idx_q == IW'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP: if (tick) begin
        valid_d = bit_s;
        ferr_d  = !bit_s;
        data_d  = bit_s ? sr_q : data_q;
        state_d = bit_s ? IDLE : BREAK;
      end
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed UART frames, scoreboard of expected pulses.
module tb_uart_rx;
  localparam int CPB  = 108;
  localparam int HALF = CPB / 2;
  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  logic       i_clk = 0, i_rst = 1, i_rx = 1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;
  int         cyc = 0, n_cmp = 0, n_bad = 0;
  logic [7:0] last_good = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  uart_rx #(.DATA_BITS(8), .CYCLES_PER_BIT(CPB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic hold(input logic lvl, input int n);
    i_rx = lvl;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  // The line is driven just after an edge, so the first edge to see start is cyc+1.
  task automatic send(input logic [7:0] d, input logic stop, input int stop_bits, input int gbit);
    exp_t       e;
    logic [7:0] x;
    x = d;
`ifndef UART_RX_MAJORITY_EN
    if (gbit >= 0) x[gbit] = ~x[gbit];
`endif
    e.err  = !stop;
    e.data = stop ? x : last_good;
    e.cyc  = cyc + 1 + 2 + HALF + 9 * CPB;
    sb.push_back(e);
    if (stop) last_good = x;
    hold(0, CPB);
    for (int i = 0; i < 8; i++)
      if (i == gbit) begin
        hold(d[i], HALF);
        hold(!d[i], 1);
        hold(d[i], CPB - HALF - 1);
      end else hold(d[i], CPB);
    hold(stop, CPB * stop_bits);
  endtask
  always @(negedge i_clk)
    if (!i_rst && (o_valid || o_frame_err)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h expected none (cycle %0d)",
                 o_valid, o_frame_err, o_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {30'd0, o_valid, o_frame_err}, mon_e.err ? 32'd1 : 32'd2);
        chk("pulse_data", {24'd0, o_data}, {24'd0, mon_e.data});
        chk("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] d;
    int         k;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_data", {24'd0, o_data}, 0);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_ferr", {31'd0, o_frame_err}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    i_rst = 0;
    hold(1, 10);
    send(8'hA5, 1, 1, -1);
    hold(1, CPB);
    send(8'h00, 1, 1, -1);
    send(8'hFF, 1, 1, -1);
    hold(1, CPB);
    k = cyc + 1;
    hold(0, 20);
    hold(1, HALF + 2 - 20);
    chk("false_start_busy_hi", {31'd0, o_busy}, 1);
    hold(1, 1);
    chk("false_start_busy_lo", {31'd0, o_busy}, 0);
    chk("false_start_edge", cyc, k + 2 + HALF);
    hold(1, CPB);
    send(8'h3C, 0, 2, -1);
    chk("break_busy", {31'd0, o_busy}, 1);
    hold(1, CPB);
    chk("break_exit_busy", {31'd0, o_busy}, 0);
    send(8'h81, 1, 1, -1);
    hold(1, CPB);
    d = 8'h5A;
    hold(0, CPB);
    for (int i = 0; i < 4; i++) hold(d[i], CPB);
    hold(d[4], HALF);
    i_rst = 1;
    #1;
    chk("midrst_data", {24'd0, o_data}, 0);
    chk("midrst_valid", {31'd0, o_valid}, 0);
    chk("midrst_ferr", {31'd0, o_frame_err}, 0);
    chk("midrst_busy", {31'd0, o_busy}, 0);
    last_good = 0;
    hold(1, 3);
    i_rst = 0;
    hold(1, 12 * CPB);
    send(8'h5A, 1, 1, -1);
    hold(1, CPB);
    send(8'h00, 1, 1, 3);
    hold(1, CPB);
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        send(d, 0, 1, -1);
        hold(1, 4 + $urandom_range(0, 50));
      end else begin
        send(d, 1, 1, -1);
        hold(1, $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 200));
      end
    end
    hold(1, 3 * CPB);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
